// File: rtl/sopc_led_pio.sv
// Avalon-MM LED output PIO with atomic set/clear registers and per-channel
// hardware blink driven by a prescaler and a programmable half-period counter.
module sopc_led_pio #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE    = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] blinkEn_q, blinkEn_d;
  logic [15:0]      period_q, period_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [15:0]      hcnt_q, hcnt_d;
  logic             phase_q, phase_d;

  logic             wrEn;
  logic             tick;
  logic [WIDTH-1:0] wdata;
  logic             unusedWriteBits;

  assign wrEn            = chipselect & ~write_n;
  assign tick            = (pcnt_q == PW'(PRESCALE - 1));
  assign wdata           = writedata[WIDTH-1:0];
  assign unusedWriteBits = ^writedata;

  // Counters advance first; a BLINK_PERIOD write then overrides them so the
  // restart always wins over a tick or toggle landing on the same edge.
  always_comb begin
    data_d    = data_q;
    blinkEn_d = blinkEn_q;
    period_d  = period_q;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    phase_d   = phase_q;

    if (tick) begin
      pcnt_d = '0;
      if (hcnt_q == period_q) begin
        hcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        hcnt_d = hcnt_q + 16'd1;
      end
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end

    if (wrEn) begin
      case (address)
        ADDR_DATA:   data_d    = wdata;
        ADDR_SET:    data_d    = data_q | wdata;
        ADDR_CLEAR:  data_d    = data_q & ~wdata;
        ADDR_BLINK:  blinkEn_d = wdata;
        ADDR_PERIOD: begin
          period_d = writedata[15:0];
          hcnt_d   = '0;
          pcnt_d   = '0;
          phase_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= RESET_VALUE;
      blinkEn_q <= '0;
      period_q  <= '0;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      phase_q   <= 1'b1;
    end else begin
      data_q    <= data_d;
      blinkEn_q <= blinkEn_d;
      period_q  <= period_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      phase_q   <= phase_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_BLINK:  readdata = 32'(blinkEn_q);
      ADDR_PERIOD: readdata = {16'd0, period_q};
      ADDR_STATUS: readdata = {31'd0, phase_q};
      default:     readdata = '0;
    endcase
  end

  // Blinking channels are gated by the shared phase; DATA=0 keeps them dark.
  assign out_port = data_q & (~blinkEn_q | {WIDTH{phase_q}});

endmodule
